// File: rtl/idli_fetch_m.sv
// SQI instruction fetch sequencer: issues quad-mode reads and streams each
// 16b instruction to the decoder as four MSB-first nibbles.
module idli_fetch_m #(
    parameter logic [14:0] RESET_PC     = 15'h0000,
    parameter int unsigned DUMMY_CYCLES = 2,
    parameter logic [7:0]  READ_CMD     = 8'h03
) (
    input  logic        i_dcd_gck,
    input  logic        i_dcd_rst_n,
    input  logic        i_fch_redirect,
    input  logic [14:0] i_fch_redirect_pc,
    output logic        o_sqi_cs_n,
    output logic [3:0]  o_sqi_sio,
    output logic        o_sqi_sio_oe,
    input  logic [3:0]  i_sqi_sio,
    output logic [3:0]  o_dcd_enc,
    output logic        o_dcd_enc_vld,
    output logic [14:0] o_fch_pc
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CMD0,
        ST_CMD1,
        ST_ADDR0,
        ST_ADDR1,
        ST_ADDR2,
        ST_ADDR3,
        ST_DUMMY,
        ST_DATA
    } state_t;

    localparam logic [3:0] DUMMY_LAST = 4'(DUMMY_CYCLES - 1);

    state_t      state;
    logic [14:0] pc;
    logic [14:0] rdr_pc;
    logic        rdr_pend;
    logic [3:0]  dummy_cnt;
    logic [1:0]  nib_cnt;

    logic        rdr_take;
    logic [14:0] rdr_tgt;
    logic [15:0] byte_addr;

    // A redirect arriving this cycle outranks an older pending one.
    always_comb begin
        rdr_take  = i_fch_redirect | rdr_pend;
        rdr_tgt   = i_fch_redirect ? i_fch_redirect_pc : rdr_pc;
        byte_addr = {pc, 1'b0};
    end

    always_ff @(posedge i_dcd_gck or negedge i_dcd_rst_n) begin
        if (!i_dcd_rst_n) begin
            state         <= ST_IDLE;
            pc            <= RESET_PC;
            rdr_pc        <= RESET_PC;
            rdr_pend      <= 1'b0;
            dummy_cnt     <= 4'd0;
            nib_cnt       <= 2'd0;
            o_sqi_cs_n    <= 1'b1;
            o_sqi_sio     <= 4'h0;
            o_sqi_sio_oe  <= 1'b0;
            o_dcd_enc     <= 4'h0;
            o_dcd_enc_vld <= 1'b0;
            o_fch_pc      <= RESET_PC;
        end else begin
            // NOTE: non-blocking defaults here are overridden by any later
            // assignment to the same register within this block.
            o_dcd_enc_vld <= 1'b0;
            if (i_fch_redirect) begin
                rdr_pend <= 1'b1;
                rdr_pc   <= i_fch_redirect_pc;
            end

            case (state)
                ST_IDLE: begin
                    if (rdr_take) begin
                        pc       <= rdr_tgt;
                        rdr_pend <= 1'b0;
                    end
                    state        <= ST_CMD0;
                    o_sqi_cs_n   <= 1'b0;
                    o_sqi_sio_oe <= 1'b1;
                    o_sqi_sio    <= READ_CMD[7:4];
                end

                ST_DATA: begin
                    o_dcd_enc     <= i_sqi_sio;
                    o_dcd_enc_vld <= 1'b1;
                    nib_cnt       <= nib_cnt + 2'd1;
                    if (nib_cnt == 2'd0)
                        o_fch_pc <= pc;
                    // Instruction boundary: the only point a redirect may cut the stream.
                    if (nib_cnt == 2'd3) begin
                        if (rdr_take) begin
                            pc         <= rdr_tgt;
                            rdr_pend   <= 1'b0;
                            state      <= ST_IDLE;
                            o_sqi_cs_n <= 1'b1;
                        end else begin
                            pc <= pc + 15'd1;
                        end
                    end
                end

                default: begin
                    if (rdr_take) begin
                        pc           <= rdr_tgt;
                        rdr_pend     <= 1'b0;
                        state        <= ST_IDLE;
                        o_sqi_cs_n   <= 1'b1;
                        o_sqi_sio_oe <= 1'b0;
                        o_sqi_sio    <= 4'h0;
                    end else begin
                        case (state)
                            ST_CMD0: begin
                                state     <= ST_CMD1;
                                o_sqi_sio <= READ_CMD[3:0];
                            end
                            ST_CMD1: begin
                                state     <= ST_ADDR0;
                                o_sqi_sio <= byte_addr[15:12];
                            end
                            ST_ADDR0: begin
                                state     <= ST_ADDR1;
                                o_sqi_sio <= byte_addr[11:8];
                            end
                            ST_ADDR1: begin
                                state     <= ST_ADDR2;
                                o_sqi_sio <= byte_addr[7:4];
                            end
                            ST_ADDR2: begin
                                state     <= ST_ADDR3;
                                o_sqi_sio <= byte_addr[3:0];
                            end
                            ST_ADDR3: begin
                                state        <= ST_DUMMY;
                                o_sqi_sio_oe <= 1'b0;
                                o_sqi_sio    <= 4'h0;
                                dummy_cnt    <= DUMMY_LAST;
                                nib_cnt      <= 2'd0;
                            end
                            ST_DUMMY: begin
                                if (dummy_cnt == 4'd0)
                                    state <= ST_DATA;
                                else
                                    dummy_cnt <= dummy_cnt - 4'd1;
                            end
                            default: state <= ST_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_idli_fetch_m.sv
// Bench for idli_fetch_m: a behavioural quad-SPI memory plus an instruction-level
// model of the delivered stream; two instances cover DUMMY_CYCLES 2/1 and PC wrap.
module tb_idli_fetch_m;

    localparam logic [7:0] READ_CMD = 8'h03;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        rdr0, rdr1;
    logic [14:0] rdr0_pc, rdr1_pc;
    logic        cs0, cs1, oe0, oe1, vld0, vld1;
    logic [3:0]  sio0, sio1, din0, din1, enc0, enc1;
    logic [14:0] fpc0, fpc1;

    idli_fetch_m #(.RESET_PC(15'h0000), .DUMMY_CYCLES(2), .READ_CMD(READ_CMD)) u_dut (
        .i_dcd_gck(clk), .i_dcd_rst_n(rst_n),
        .i_fch_redirect(rdr0), .i_fch_redirect_pc(rdr0_pc),
        .o_sqi_cs_n(cs0), .o_sqi_sio(sio0), .o_sqi_sio_oe(oe0), .i_sqi_sio(din0),
        .o_dcd_enc(enc0), .o_dcd_enc_vld(vld0), .o_fch_pc(fpc0)
    );

    idli_fetch_m #(.RESET_PC(15'h7FFF), .DUMMY_CYCLES(1), .READ_CMD(READ_CMD)) u_dut_wrap (
        .i_dcd_gck(clk), .i_dcd_rst_n(rst_n),
        .i_fch_redirect(rdr1), .i_fch_redirect_pc(rdr1_pc),
        .o_sqi_cs_n(cs1), .o_sqi_sio(sio1), .o_sqi_sio_oe(oe1), .i_sqi_sio(din1),
        .o_dcd_enc(enc1), .o_dcd_enc_vld(vld1), .o_fch_pc(fpc1)
    );

    logic [15:0] mem [32768];
    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Model state, one slot per instance.
    logic [14:0] want[2], cur[2];
    logic [15:0] instr[2], maddr[2];
    logic        last_vld[2];
    int          idx[2], ninstr[2], cs_low_cnt[2], cs_hi[2], mcnt[2], ntx[2];

    function automatic logic [14:0] reset_pc_of(int b);
        return (b == 0) ? 15'h0000 : 15'h7FFF;
    endfunction

    function automatic int dummy_of(int b);
        return (b == 0) ? 2 : 1;
    endfunction

    task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            want[b] = reset_pc_of(b);
            cur[b] = reset_pc_of(b);
            instr[b] = 16'h0; maddr[b] = 16'h0; last_vld[b] = 1'b0;
            idx[b] = 0; ninstr[b] = 0; cs_low_cnt[b] = 0; cs_hi[b] = 0; mcnt[b] = 0; ntx[b] = 0;
        end
    endtask

    // Decoder-side view: instructions arrive as 4 contiguous nibbles, PC held.
    task automatic mon(int b, logic vld, logic [3:0] enc, logic [14:0] fpc, logic cs_n);
        last_vld[b] = vld;
        if (cs_n && ntx[b] > 0) cs_hi[b]++;
        cs_low_cnt[b] = cs_n ? 0 : cs_low_cnt[b] + 1;
        if (vld) begin
            if (idx[b] == 0) begin
                check($sformatf("pc_first%0d", b), fpc, want[b]);
                cur[b] = want[b];
                want[b] = want[b] + 15'd1;
                instr[b] = 16'h0;
            end else begin
                check($sformatf("pc_hold%0d", b), fpc, cur[b]);
            end
            instr[b] = {instr[b][11:0], enc};
            idx[b]++;
            if (idx[b] == 4) begin
                check($sformatf("instr%0d", b), instr[b], mem[cur[b]]);
                idx[b] = 0;
                ninstr[b]++;
            end
        end else if (idx[b] != 0) begin
            check($sformatf("vld_gap%0d", b), vld, 1'b1);
            idx[b] = 0;
        end
    endtask

    // Quad-SPI memory: decodes cmd/address from the bus and streams data.
    task automatic mem_step(int b, logic cs_n, logic [3:0] sio, logic oe, output logic [3:0] din);
        int d;
        int j;
        logic [14:0] w;
        d = dummy_of(b);
        din = 4'h0;
        if (cs_n) begin
            mcnt[b] = 0;
        end else begin
            if (mcnt[b] == 0) begin
                ntx[b]++;
                check($sformatf("cmd_hi%0d", b), {oe, sio}, {1'b1, READ_CMD[7:4]});
            end else if (mcnt[b] == 1) begin
                check($sformatf("cmd_lo%0d", b), {oe, sio}, {1'b1, READ_CMD[3:0]});
            end else if (mcnt[b] <= 5) begin
                check($sformatf("addr_oe%0d", b), oe, 1'b1);
                maddr[b] = {maddr[b][11:0], sio};
            end else if (mcnt[b] < 6 + d) begin
                check($sformatf("dummy_bus%0d", b), {oe, sio}, 5'h00);
            end else begin
                j = mcnt[b] - 6 - d;
                if (j == 0) check($sformatf("addr%0d", b), maddr[b], {want[b], 1'b0});
                check($sformatf("data_oe%0d", b), oe, 1'b0);
                w = maddr[b][15:1] + 15'(j / 4);
                din = 4'(mem[w] >> (4 * (3 - (j % 4))));
            end
            mcnt[b]++;
        end
    endtask

    task automatic tick();
        logic [3:0] d0, d1;
        @(negedge clk);
        rdr0 = 1'b0;
        cyc++;
        if (rst_n) begin
            mon(0, vld0, enc0, fpc0, cs0);
            mon(1, vld1, enc1, fpc1, cs1);
            mem_step(0, cs0, sio0, oe0, d0);
            mem_step(1, cs1, sio1, oe1, d1);
            din0 = d0;
            din1 = d1;
        end
    endtask

    task automatic do_redirect(logic [14:0] tgt);
        rdr0 = 1'b1;
        rdr0_pc = tgt;
        want[0] = tgt;
    endtask

    task automatic start_run();
        rst_n = 1'b0;
        rdr0 = 1'b0;
        din0 = 4'h0;
        din1 = 4'h0;
        repeat (2) @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        cyc = 0;
    endtask

    initial begin
        logic [3:0]  exp_sio[6];
        logic [15:0] words[3];
        logic [15:0] w0;
        int k;
        int n0;
        int tx0;

        exp_sio = '{4'h0, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0};
        rst_n = 1'b0; rdr0 = 1'b0; rdr0_pc = 15'h0; rdr1 = 1'b0; rdr1_pc = 15'h0;
        din0 = 4'h0; din1 = 4'h0;
        model_reset();
        for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
        mem[0] = 16'hA5C3;

        // Reset values.
        #12;
        check("rst_cs", cs0, 1'b1);
        check("rst_sio", {oe0, sio0}, 5'h00);
        check("rst_enc", {vld0, enc0}, 5'h00);
        check("rst_pc", fpc0, 15'h0000);
        check("rst_pc_wrap", fpc1, 15'h7FFF);

        // First fetch after reset: cycle-exact bus and delivery timing.
        start_run();
        #1;
        check("c0_cs", cs0, 1'b1);
        check("c0_vld", vld0, 1'b0);
        w0 = 16'hA5C3;
        for (int c = 1; c <= 13; c++) begin
            tick();
            if (c == 1) check("c1_cs", cs0, 1'b0);
            if (c <= 6) check($sformatf("c%0d_sio", c), sio0, exp_sio[c-1]);
            if (c == 7) check("c7_oe", oe0, 1'b0);
            if (c == 9) check("c9_vld", vld0, 1'b0);
            if (c >= 10) begin
                check($sformatf("c%0d_enc", c), {vld0, enc0}, {1'b1, 4'(w0 >> (4 * (13 - c)))});
                check($sformatf("c%0d_pc", c), fpc0, 15'h0000);
            end
        end

        // Back-to-back stream; wrap instance streams 7FFF then 0000.
        words = '{16'h1234, 16'h5678, 16'h9ABC};
        mem[0] = words[0]; mem[1] = words[1]; mem[2] = words[2];
        start_run();
        for (int c = 1; c <= 21; c++) begin
            tick();
            if (c >= 10) begin
                check($sformatf("s%0d_enc", c), {vld0, enc0},
                      {1'b1, 4'(words[(c-10)/4] >> (4 * (3 - ((c - 10) % 4))))});
                check($sformatf("s%0d_pc", c), fpc0, 15'((c - 10) / 4));
            end
        end
        check("wrap_count", ninstr[1] >= 2, 1'b1);
        check("wrap_cs", cs_hi[1], 0);

        // Redirect during nibble 1 of the instruction at pc 5.
        for (k = 0; k < 300; k++) begin
            if (last_vld[0] && cur[0] == 15'd5 && idx[0] == 2) break;
            tick();
        end
        check("reach_pc5", k < 300, 1'b1);
        do_redirect(15'h0100);
        n0 = ninstr[0];
        for (k = 0; k < 20; k++) begin
            tick();
            if (ninstr[0] != n0) break;
        end
        check("pc5_done", ninstr[0], n0 + 1);
        check("rd_idle_cs", cs0, 1'b1);
        tick();
        check("rd_restart_cs", cs0, 1'b0);
        for (k = 0; k < 100; k++) begin
            if (last_vld[0] && idx[0] == 1) break;
            tick();
        end
        check("rd_target", cur[0], 15'h0100);

        // Two redirects within one instruction: only the latest restarts.
        tx0 = ntx[0];
        do_redirect(15'h0010);
        tick();
        do_redirect(15'h0020);
        for (k = 0; k < 100; k++) begin
            tick();
            if (last_vld[0] && idx[0] == 1 && cur[0] == 15'h0020) break;
        end
        check("latest_wins", cur[0], 15'h0020);
        check("one_restart", ntx[0] - tx0, 1);

        // Redirect during ADDR0 aborts the read.
        do_redirect(15'h0040);
        for (k = 0; k < 100; k++) begin
            tick();
            if (cs_low_cnt[0] == 3) break;
        end
        check("reach_addr0", cs_low_cnt[0], 3);
        do_redirect(15'h0300);
        tick();
        check("abort_cs", cs0, 1'b1);
        for (k = 0; k < 100; k++) begin
            tick();
            if (last_vld[0] && idx[0] == 1) break;
        end
        check("abort_target", cur[0], 15'h0300);

        // Redirect in the IDLE cycle is used for the next command.
        do_redirect(15'h7FF0);
        n0 = ninstr[0];
        for (k = 0; k < 20; k++) begin
            tick();
            if (ninstr[0] != n0) break;
        end
        check("idle_cs", cs0, 1'b1);
        do_redirect(15'h7FFE);
        tick();
        check("idle_rd_cs", cs0, 1'b0);
        for (k = 0; k < 100; k++) begin
            tick();
            if (last_vld[0] && idx[0] == 1) break;
        end
        check("idle_target", cur[0], 15'h7FFE);

        // Random redirects mid-instruction against the model.
        for (int i = 0; i < 1500; i++) begin
            tick();
            if (last_vld[0] && idx[0] >= 1 && idx[0] <= 3 && $urandom_range(5) == 0)
                do_redirect(15'($urandom));
        end
        check("rand_progress", ninstr[0] > 20, 1'b1);
        check("wrap_cs_long", cs_hi[1], 0);

        // Reset at nibble 2 with a redirect pending: full restart at RESET_PC.
        for (k = 0; k < 100; k++) begin
            if (last_vld[0] && idx[0] == 2) break;
            tick();
        end
        do_redirect(15'h0555);
        tick();
        check("at_nib2", idx[0], 3);
        rst_n = 1'b0;
        #1;
        check("mid_rst_vld", vld0, 1'b0);
        check("mid_rst_cs", cs0, 1'b1);
        check("mid_rst_bus", {oe0, sio0}, 5'h00);
        check("mid_rst_pc", fpc0, 15'h0000);
        start_run();
        for (int c = 1; c <= 13; c++) begin
            tick();
            if (c == 1) check("rr_c1_cs", cs0, 1'b0);
            if (c <= 6) check($sformatf("rr_c%0d_sio", c), sio0, exp_sio[c-1]);
            if (c == 10) check("rr_c10", {vld0, fpc0}, {1'b1, 15'h0000});
        end
        repeat (20) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
